// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply
// (MUL_BITS per cycle), restoring divide (one bit per cycle), single fix-up cycle.
module iter_muldiv #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             op_u,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MUL_CYC = WIDTH / MUL_BITS;
  localparam int CW      = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_MADD = 3'd2;
  localparam logic [2:0] OP_MSUB = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5;
  localparam logic [2:0] OP_MTLO = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d;
  logic                dbzo_q, dbzo_d;
  logic                dbz_q, dbz_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2:0]          opl_q, opl_d;

  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;
  logic [WIDTH:0]      rem_q, rem_d;

  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH+MUL_BITS-1:0] mul_sum;
  logic [2*WIDTH-1:0]  prod_next;
  logic [WIDTH:0]      shifted, diff;
  logic                ge;
  logic [2*WIDTH-1:0]  prod_s;
  logic [WIDTH-1:0]    quot_s, rem_s;

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbzo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // Signed ops iterate on magnitudes; |MIN| is representable as an unsigned WIDTH value.
  assign a_neg = ~op_u & a[WIDTH-1];
  assign b_neg = ~op_u & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Partial sum needs MUL_BITS headroom above the upper product half.
  assign mul_sum   = {{MUL_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]}
                   + ({{MUL_BITS{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, mplier_q[MUL_BITS-1:0]});
  assign prod_next = {mul_sum, prod_q[WIDTH-1:MUL_BITS]};

  assign shifted = (rem_q << 1) | {{WIDTH{1'b0}}, mplier_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, mcand_q});
  assign diff    = shifted - {1'b0, mcand_q};

  assign prod_s = neg_res_q ? -prod_q : prod_q;
  assign quot_s = neg_res_q ? -mplier_q : mplier_q;
  assign rem_s  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbzo_d    = 1'b0;
    dbz_d     = dbz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opl_d     = opl_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    rem_d     = rem_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MUL, OP_MADD, OP_MSUB: begin
                state_d   = S_MUL;
                cnt_d     = CW'(MUL_CYC);
                opl_d     = op;
                mcand_d   = a_mag;
                mplier_d  = b_mag;
                prod_d    = '0;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = 1'b0;
                dbz_d     = 1'b0;
              end
              OP_DIV: begin
                opl_d = op;
                if (b == '0) begin
                  // Divide by zero skips iteration: FIX emits hi=a, lo=all ones.
                  state_d   = S_FIX;
                  cnt_d     = '0;
                  mplier_d  = '1;
                  rem_d     = {1'b0, a};
                  neg_res_d = 1'b0;
                  neg_rem_d = 1'b0;
                  dbz_d     = 1'b1;
                end else begin
                  state_d   = S_DIV;
                  cnt_d     = CW'(WIDTH);
                  mcand_d   = b_mag;
                  mplier_d  = a_mag;
                  rem_d     = '0;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  dbz_d     = 1'b0;
                end
              end
              OP_MTHI: begin
                hi_d   = a;
                done_d = 1'b1;
              end
              OP_MTLO: begin
                lo_d   = a;
                done_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          prod_d   = prod_next;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_DIV: begin
          rem_d    = ge ? diff : shifted;
          mplier_d = {mplier_q[WIDTH-2:0], ge};
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          dbzo_d  = dbz_q;
          case (opl_q)
            OP_MUL:  {hi_d, lo_d} = prod_s;
            OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            OP_DIV: begin
              lo_d = quot_s;
              hi_d = rem_s;
            end
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbzo_q    <= 1'b0;
      dbz_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opl_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbzo_q    <= dbzo_d;
      dbz_q     <= dbz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opl_q     <= opl_d;
    end
  end

  always_ff @(posedge clock) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
    rem_q    <= rem_d;
  end

endmodule
